// File: rtl/cdr_dbg_monitor.sv
// CDR debug monitor: bang-bang lock detector, control-word snapshot and a
// registered, mode-selected debug byte port.
module cdr_dbg_monitor #(
   parameter int CTRL_W    = 32,
   parameter int FCW_W     = 32,
   parameter int WIN_LOG2  = 6,
   parameter int LOCK_THR  = 8,
   parameter int LOCK_WINS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     sample_en,
   input  logic                     d_bb,
   input  logic [1:0]               d_q2,
   input  logic signed [CTRL_W-1:0] v_ctrl,
   input  logic signed [FCW_W-1:0]  dfcw,
   input  logic                     cmd_snap,
   input  logic [1:0]               mode,
   input  logic [2:0]               byte_sel,
   output logic [7:0]               dbg_out,
   output logic                     locked,
   output logic                     snap_valid
);

   localparam int BAL_W = WIN_LOG2 + 2;
   localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

   logic [WIN_LOG2-1:0]       win_cnt;
   logic signed [BAL_W-1:0]   bal, bal_next, bal_step, last_bal;
   logic [3:0]                good_cnt, good_next;
   logic                      win_close, bal_good;
   logic                      snap_prev, snap_armed, snap_edge;
   logic signed [CTRL_W-1:0]  snap_ctrl;
   logic signed [FCW_W-1:0]   snap_fcw;
   logic [7:0]                ctrl_byte, fcw_byte, dbg_next;

   function automatic logic signed [5:0] sat6(input logic signed [BAL_W-1:0] v);
      if (int'(v) > 31)
         return 6'sd31;
      else if (int'(v) < -32)
         return -6'sd32;
      else
         return 6'(v);
   endfunction

   // Window balance including the current sample, so the closing sample counts.
   always_comb begin
      bal_step  = d_bb ? BAL_W'(1) : {BAL_W{1'b1}};
      bal_next  = sample_en ? bal + bal_step : bal;
      win_close = sample_en && (win_cnt == WIN_LAST);
      bal_good  = (int'(bal_next) <= LOCK_THR) && (int'(bal_next) >= -LOCK_THR);
      if (!bal_good)
         good_next = '0;
      else if (good_cnt == 4'(LOCK_WINS))
         good_next = good_cnt;
      else
         good_next = good_cnt + 4'd1;
   end

   // snap_armed blocks a cmd_snap that was already high when reset released.
   assign snap_edge = cmd_snap && !snap_prev && snap_armed;

   always_comb begin
      ctrl_byte = (int'(byte_sel) < CTRL_W/8) ? 8'(snap_ctrl >> {byte_sel, 3'b000}) : 8'h00;
      fcw_byte  = (int'(byte_sel) < FCW_W/8)  ? 8'(snap_fcw  >> {byte_sel, 3'b000}) : 8'h00;
      case (mode)
         2'd0:    dbg_next = {dfcw[FCW_W-1], v_ctrl[CTRL_W-1], d_q2[1], d_q2[0],
                              d_bb, locked, sample_en, 1'b0};
         2'd1:    dbg_next = ctrl_byte;
         2'd2:    dbg_next = fcw_byte;
         default: dbg_next = {locked, snap_valid, sat6(last_bal)};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         win_cnt    <= '0;
         bal        <= '0;
         last_bal   <= '0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         snap_prev  <= 1'b0;
         snap_armed <= ~cmd_snap;
         snap_ctrl  <= '0;
         snap_fcw   <= '0;
         snap_valid <= 1'b0;
         dbg_out    <= '0;
      end else begin
         snap_prev  <= cmd_snap;
         snap_armed <= snap_armed | ~cmd_snap;
         if (snap_edge) begin
            snap_ctrl  <= v_ctrl;
            snap_fcw   <= dfcw;
            snap_valid <= 1'b1;
         end
         if (sample_en)
            win_cnt <= win_cnt + 1'b1;
         if (win_close) begin
            bal      <= '0;
            last_bal <= bal_next;
            good_cnt <= good_next;
            locked   <= (good_next == 4'(LOCK_WINS));
         end else begin
            bal <= bal_next;
         end
         dbg_out <= ena ? dbg_next : 8'h00;
      end
   end

endmodule

// File: tb/tb_cdr_dbg_monitor.sv
// Bench for cdr_dbg_monitor: queue-based reference model, per-cycle compare
// process, directed scenarios with literal expectations, then random traffic.
module tb_cdr_dbg_monitor;

   localparam int CTRL_W    = 32;
   localparam int FCW_W     = 32;
   localparam int WIN_LOG2  = 6;
   localparam int LOCK_THR  = 8;
   localparam int LOCK_WINS = 4;
   localparam int WIN_LEN   = 1 << WIN_LOG2;

   logic                     clk = 1'b0;
   logic                     rst_n, ena, sample_en, d_bb, cmd_snap;
   logic [1:0]               d_q2, mode;
   logic [2:0]               byte_sel;
   logic signed [CTRL_W-1:0] v_ctrl;
   logic signed [FCW_W-1:0]  dfcw;
   logic [7:0]               dbg_out;
   logic                     locked, snap_valid;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // Reference model state
   bit          m_q[$];
   int          m_good, m_last_bal;
   bit          m_locked, m_snap_valid, m_prev_cmd;
   logic [63:0] m_snap_ctrl, m_snap_fcw;
   logic [7:0]  exp_dbg;

   cdr_dbg_monitor #(
      .CTRL_W(CTRL_W), .FCW_W(FCW_W), .WIN_LOG2(WIN_LOG2),
      .LOCK_THR(LOCK_THR), .LOCK_WINS(LOCK_WINS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sample_en(sample_en), .d_bb(d_bb),
      .d_q2(d_q2), .v_ctrl(v_ctrl), .dfcw(dfcw), .cmd_snap(cmd_snap),
      .mode(mode), .byte_sel(byte_sel), .dbg_out(dbg_out), .locked(locked),
      .snap_valid(snap_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] sat_field(input int b);
      int s;
      logic [31:0] w;
      s = (b > 31) ? 31 : ((b < -32) ? -32 : b);
      w = s;
      return w[5:0];
   endfunction

   // One clock edge of the specified behaviour, from the inputs present at the edge.
   task automatic model_step();
      int ones;
      if (!rst_n) begin
         m_q.delete();
         m_good = 0; m_last_bal = 0; m_locked = 0; m_snap_valid = 0;
         m_snap_ctrl = '0; m_snap_fcw = '0; exp_dbg = 8'h00;
         m_prev_cmd = cmd_snap;
         return;
      end
      if (!ena)
         exp_dbg = 8'h00;
      else case (mode)
         2'd0: exp_dbg = {dfcw[FCW_W-1], v_ctrl[CTRL_W-1], d_q2, d_bb, m_locked, sample_en, 1'b0};
         2'd1: exp_dbg = (int'(byte_sel) < CTRL_W/8) ? m_snap_ctrl[byte_sel*8 +: 8] : 8'h00;
         2'd2: exp_dbg = (int'(byte_sel) < FCW_W/8) ? m_snap_fcw[byte_sel*8 +: 8] : 8'h00;
         default: exp_dbg = {m_locked, m_snap_valid, sat_field(m_last_bal)};
      endcase
      if (cmd_snap && !m_prev_cmd) begin
         m_snap_ctrl  = {32'h0, v_ctrl};
         m_snap_fcw   = {32'h0, dfcw};
         m_snap_valid = 1;
      end
      m_prev_cmd = cmd_snap;
      if (sample_en) begin
         m_q.push_back(d_bb);
         if (m_q.size() == WIN_LEN) begin
            ones = 0;
            foreach (m_q[i]) ones += m_q[i];
            m_last_bal = 2 * ones - WIN_LEN;
            if (m_last_bal <= LOCK_THR && m_last_bal >= -LOCK_THR)
               m_good = (m_good + 1 > LOCK_WINS) ? LOCK_WINS : m_good + 1;
            else
               m_good = 0;
            m_locked = (m_good == LOCK_WINS);
            m_q.delete();
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("dbg_out", dbg_out, exp_dbg);
         check("locked", locked, m_locked);
         check("snap_valid", snap_valid, m_snap_valid);
      end
   end

   task automatic alt_samples(input int n, input bit chk_lock);
      for (int i = 0; i < n; i++) begin
         sample_en = 1; d_bb = i[0];
         tick();
         if (chk_lock && i == n - 2) check("lock_early", locked, 1'b0);
         if (chk_lock && i == n - 1) check("lock_on_time", locked, 1'b1);
      end
      sample_en = 0;
   endtask

   initial begin
      rst_n = 0; ena = 1; sample_en = 0; d_bb = 0; cmd_snap = 0; d_q2 = 0;
      mode = 3; byte_sel = 0; v_ctrl = '0; dfcw = '0;
      m_q.delete();
      m_good = 0; m_last_bal = 0; m_locked = 0; m_snap_valid = 0; m_prev_cmd = 0;
      m_snap_ctrl = '0; m_snap_fcw = '0; exp_dbg = '0;
      repeat (3) tick();
      chk_en = 1;
      check("rst_dbg", dbg_out, 8'h00);
      check("rst_locked", locked, 1'b0);
      check("rst_snap_valid", snap_valid, 1'b0);

      // Four balanced windows lock the detector exactly after sample 256
      rst_n = 1; mode = 3;
      alt_samples(256, 1);
      tick();
      check("mode3_locked_nosnap", dbg_out, 8'h80);

      // One all-late window breaks lock and saturates the balance field
      for (int i = 0; i < WIN_LEN; i++) begin
         sample_en = 1; d_bb = 1;
         tick();
         if (i == WIN_LEN - 2) check("still_locked", locked, 1'b1);
      end
      check("unlock", locked, 1'b0);
      sample_en = 0;
      tick();
      check("mode3_sat", dbg_out, 8'h1F);

      // Snapshot and byte readout
      v_ctrl = 32'h12345678; dfcw = 32'hFEDCBA98; cmd_snap = 1; mode = 0;
      tick();
      check("snap_valid_set", snap_valid, 1'b1);
      cmd_snap = 0; v_ctrl = 32'h0; dfcw = 32'h0;
      mode = 1; byte_sel = 0; tick(); check("ctrl_b0", dbg_out, 8'h78);
      byte_sel = 3; tick(); check("ctrl_b3", dbg_out, 8'h12);
      byte_sel = 5; tick(); check("ctrl_b5", dbg_out, 8'h00);
      mode = 2; byte_sel = 1; tick(); check("fcw_b1", dbg_out, 8'hBA);

      // Held-high cmd_snap captures only its first cycle
      cmd_snap = 1;
      for (int i = 0; i < 10; i++) begin
         v_ctrl = 32'hA5000011 + i * 32'h101;
         tick();
      end
      cmd_snap = 0;
      mode = 1; byte_sel = 0; tick(); check("hold_b0", dbg_out, 8'h11);
      byte_sel = 1; tick(); check("hold_b1", dbg_out, 8'h00);
      byte_sel = 3; tick(); check("hold_b3", dbg_out, 8'hA5);

      // Output enable gates only dbg_out
      mode = 0; ena = 0; sample_en = 1; d_bb = 1; d_q2 = 2'b10;
      v_ctrl = 32'h80000000; dfcw = 32'h0;
      tick();
      check("ena_off", dbg_out, 8'h00);
      check("ena_off_locked", locked, 1'b0);
      ena = 1;
      tick();
      check("ena_on_live", dbg_out, 8'h6A);
      sample_en = 0; d_q2 = 0;

      // Reset mid-window while locked and snapped
      rst_n = 0; tick(); rst_n = 1;
      cmd_snap = 1; tick(); cmd_snap = 0;
      mode = 3;
      alt_samples(256, 1);
      for (int i = 0; i < 29; i++) begin
         sample_en = 1; d_bb = 1; tick();
      end
      check("pre_rst_locked", locked, 1'b1);
      check("pre_rst_snap", snap_valid, 1'b1);
      rst_n = 0; tick();
      check("mid_rst_dbg", dbg_out, 8'h00);
      check("mid_rst_locked", locked, 1'b0);
      check("mid_rst_snap", snap_valid, 1'b0);
      rst_n = 1;
      alt_samples(256, 1);

      // cmd_snap held through reset release does not capture
      cmd_snap = 1; rst_n = 0; tick(); rst_n = 1;
      repeat (3) tick();
      check("held_thru_rst", snap_valid, 1'b0);
      cmd_snap = 0; tick();
      cmd_snap = 1; tick();
      check("rearm_capture", snap_valid, 1'b1);
      cmd_snap = 0;

      // Randomised traffic
      for (int blk = 0; blk < 40; blk++) begin
         int p_late;
         p_late = (blk % 4 == 0) ? 80 : 50;
         for (int i = 0; i < 150; i++) begin
            rst_n     = ($urandom_range(0, 599) != 0);
            ena       = ($urandom_range(0, 9) != 0);
            sample_en = ($urandom_range(0, 9) < 8);
            d_bb      = ($urandom_range(0, 99) < p_late);
            d_q2      = 2'($urandom);
            v_ctrl    = $urandom;
            dfcw      = $urandom;
            cmd_snap  = ($urandom_range(0, 9) < 3);
            mode      = 2'($urandom);
            byte_sel  = 3'($urandom);
            tick();
         end
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cdr_dbg_monitor.md
CDR_DBG_MONITOR -- requirements
Module: cdr_dbg_monitor

Parameters
REQ-001 CTRL_W, default 32, width of v_ctrl; SHALL be a multiple of 8 in 8..64.
REQ-002 FCW_W, default 32, width of dfcw; SHALL be a multiple of 8 in 8..64.
REQ-003 WIN_LOG2, default 6, lock window length = 2^WIN_LOG2 sample_en pulses; range 2..12.
REQ-004 LOCK_THR, default 8, max |window balance| still counted as a good window.
REQ-005 LOCK_WINS, default 4, consecutive good windows required to assert locked; range 1..15.

Interface
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ena  in  1  output enable; gates dbg_out only.
REQ-009 sample_en  in  1  CDR sample strobe; qualifies d_bb.
REQ-010 d_bb  in  1  bang-bang phase decision, 1 = late, 0 = early.
REQ-011 d_q2  in  2  quantised phase error, live debug only.
REQ-012 v_ctrl  in  CTRL_W  signed loop-filter control word.
REQ-013 dfcw  in  FCW_W  signed frequency control word delta.
REQ-014 cmd_snap  in  1  snapshot request, rising-edge sensitive.
REQ-015 mode  in  2  readout mode select.
REQ-016 byte_sel  in  3  byte index for snapshot readout, 0 = LSB.
REQ-017 dbg_out  out  8  registered debug byte.
REQ-018 locked  out  1  registered lock indication.
REQ-019 snap_valid  out  1  registered, sticky snapshot-taken flag.

Function
REQ-020 Window counter (WIN_LOG2 bits) SHALL increment only on cycles with sample_en=1, wrapping 2^WIN_LOG2-1 -> 0.
REQ-021 Balance accumulator (signed, WIN_LOG2+2 bits) SHALL add +1 on sample_en & d_bb=1, -1 on sample_en & d_bb=0, and hold otherwise.
REQ-022 The window-closing sample (counter = 2^WIN_LOG2-1 with sample_en=1) SHALL be included in the window; the accumulator SHALL restart at 0 on the next cycle; the final balance SHALL be latched into last_bal.
REQ-023 At each window close, a good-window counter SHALL increment, saturating at LOCK_WINS, if |final balance| <= LOCK_THR, and SHALL clear to 0 otherwise.
REQ-024 locked SHALL be 1 exactly when the good-window counter equals LOCK_WINS; it SHALL assert and deassert on the cycle after the window-closing sample.
REQ-025 cmd_snap SHALL be registered; a rising edge is cmd_snap=1 while its registered copy is 0; a held-high cmd_snap SHALL capture only once.
REQ-026 On a rising edge in cycle N, snap_ctrl and snap_fcw SHALL hold v_ctrl and dfcw of cycle N from edge N+1, and snap_valid SHALL go to 1 at the same edge.
REQ-027 snap_valid SHALL stay 1 until reset; a later edge SHALL overwrite both snapshot registers.
REQ-028 dbg_out SHALL be registered, one-cycle latency from mode, byte_sel, inputs and internal state.
REQ-029 mode 0: dbg_out = {dfcw[MSB], v_ctrl[MSB], d_q2[1], d_q2[0], d_bb, locked, sample_en, 0}.
REQ-030 mode 1: dbg_out = snap_ctrl byte byte_sel; 0x00 if byte_sel >= CTRL_W/8.
REQ-031 mode 2: dbg_out = snap_fcw byte byte_sel; 0x00 if byte_sel >= FCW_W/8.
REQ-032 mode 3: dbg_out = {locked, snap_valid, last_bal saturated to 6-bit signed (+31/-32)}.
REQ-033 ena=0 SHALL force dbg_out to 0x00 on the next edge; locked, snap_valid and all internal state SHALL continue unaffected.
REQ-034 A snapshot edge on a window-closing cycle SHALL process both events in the same cycle, with no mutual interference.

Reset
REQ-035 rst_n=0 at an edge SHALL clear the window counter, accumulator, last_bal, good-window counter, snapshot registers, registered cmd_snap, dbg_out, locked and snap_valid to 0.
REQ-036 Reset SHALL take priority over all simultaneous events.
REQ-037 Reset mid-window SHALL discard the partial window; a cmd_snap held high through reset release SHALL not capture until it falls and rises again.

Verification (default parameters)
REQ-038 Alternating d_bb on every sample_en, 256 samples -> locked=1 the cycle after sample 256 (4th good window), not earlier; mode 3 reads 0xC0 if snapped, else 0x80.
REQ-039 Locked, then one 64-sample window of all d_bb=1 -> locked=0 the cycle after that window closes; mode 3 balance field = 0x1F (saturated +31).
REQ-040 v_ctrl=0x12345678, dfcw=0xFEDCBA98, cmd_snap pulse in cycle N; then mode=1/byte_sel=0 -> 0x78, byte_sel=3 -> 0x12, byte_sel=5 -> 0x00; mode=2/byte_sel=1 -> 0xBA; snap_valid=1 from edge N+1.
REQ-041 cmd_snap held high 10 cycles while v_ctrl changes every cycle -> snapshot equals v_ctrl of the first high cycle only.
REQ-042 ena=0 with mode 0 and active inputs -> dbg_out=0x00 one cycle later; ena back to 1 -> live flags one cycle later; locked unaffected throughout.
REQ-043 rst_n low for 1 cycle at window sample 30 with snap_valid=1 -> all outputs 0 next cycle; lock needs 4 full fresh windows.
